// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module      : fifo_uart_tx
// Description : Pops characters from a show-ahead FIFO and serialises them as
//               8N1-style UART frames (start, LSB-first data, stop). Defining
//               UART_TX_PARITY_EN adds an even-parity bit between data and stop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_read_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int c_CNT_W      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_IDX_W      = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_WIDTH - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd3;
`endif
  localparam logic [2:0] c_STOP   = 3'd4;

  logic [2:0]            r_state;
  logic [c_CNT_W-1:0]    r_cnt;
  logic [c_IDX_W-1:0]    r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_read_en;
  logic                  r_done;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
`endif

  logic                  w_bit_end;
  logic [DATA_WIDTH-1:0] w_shift_next;

  assign w_bit_end    = (r_cnt == c_CNT_LAST);
  assign w_shift_next = r_shift >> 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_read_en <= 1'b0;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_read_en <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        c_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          r_cnt  <= '0;
          // The pop strobe and the start bit appear together on the next cycle.
          if (!fifo_empty) begin
            r_shift   <= fifo_data;
`ifdef UART_TX_PARITY_EN
            r_parity  <= ^fifo_data;
`endif
            r_state   <= c_START;
            r_read_en <= 1'b1;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
          end
        end

        c_START: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= c_DATA;
            r_tx      <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        c_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == c_IDX_LAST) begin
              r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              r_state   <= c_PARITY;
              r_tx      <= r_parity;
`else
              r_state   <= c_STOP;
              r_tx      <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= w_shift_next;
              r_tx      <= w_shift_next[0];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        c_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= c_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif

        c_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= c_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: begin
          r_state   <= c_IDLE;
          r_cnt     <= '0;
          r_bit_idx <= '0;
          r_tx      <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign tx           = r_tx;
  assign busy         = r_busy;
  assign fifo_read_en = r_read_en;
  assign tx_done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module      : tb_fifo_uart_tx
// Description : Self-checking bench for fifo_uart_tx with a queue-based FIFO
//               model, a line decoder and a scoreboard of expected characters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;

  localparam int c_CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int c_FB = 11;
`else
  localparam int c_FB = 10;
`endif

  logic       clk;
  logic       reset_n;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  fifo_uart_tx #(
    .DATA_WIDTH (8),
    .CLK_FREQ   (1000),
    .BAUD       (100)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_read_en (fifo_read_en),
    .tx           (tx),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] fq[$];
  logic [7:0] sb[$];

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  int pops = 0;
  int done_cnt = 0;
  int frames_done = 0;
  int last_start = 0;
  int prev_start = 0;
  int last_done = 0;
  int mon_cnt = 0;
  bit mon_act = 0;
  bit mon_bad = 0;
  logic [c_FB-1:0] mon_bits;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic fifo_refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : fq[0];
  endtask

  task automatic push_byte(input logic [7:0] d);
    fq.push_back(d);
    sb.push_back(d);
    fifo_refresh();
  endtask

  // Decodes the line one cycle at a time; frame timing is relative to the start edge.
  task automatic monitor();
    int k;
    int r;
    logic [7:0] e;
    if (reset_n !== 1'b1) begin
      mon_act = 0;
      return;
    end
    if (tx_done === 1'b1) begin
      done_cnt++;
      last_done = cyc;
    end
    if (!mon_act && tx === 1'b0) begin
      mon_act    = 1;
      mon_cnt    = 0;
      mon_bad    = 0;
      prev_start = last_start;
      last_start = cyc;
    end
    if (mon_act) begin
      if (mon_cnt < c_FB * c_CPB) begin
        k = mon_cnt / c_CPB;
        r = mon_cnt % c_CPB;
        if (r == 0) mon_bits[k] = tx;
        else if (tx !== mon_bits[k]) mon_bad = 1;
        if (busy !== 1'b1 || tx_done !== 1'b0) mon_bad = 1;
        mon_cnt++;
      end else begin
        check("frame_end_done_busy_tx", {29'd0, tx_done, busy, tx}, 32'd5);
        check("bit_hold_busy", {31'd0, mon_bad}, 32'd0);
        if (sb.size() == 0) begin
          check("scoreboard_underflow", sb.size(), 32'd1);
        end else begin
          e = sb.pop_front();
          check("start_bit", {31'd0, mon_bits[0]}, 32'd0);
          check("data_bits", {24'd0, mon_bits[8:1]}, {24'd0, e});
`ifdef UART_TX_PARITY_EN
          check("parity_bit", {31'd0, mon_bits[9]}, {31'd0, ^e});
`endif
          check("stop_bit", {31'd0, mon_bits[c_FB-1]}, 32'd1);
        end
        mon_act = 0;
        frames_done++;
      end
    end
  endtask

  task automatic tick();
    logic pop;
    pop = fifo_read_en;
    @(posedge clk);
    #1;
    cyc++;
    if (pop === 1'b1) begin
      pops++;
      if (fq.size() == 0) check("pop_while_empty", 32'd1, 32'd0);
      else void'(fq.pop_front());
    end
    fifo_refresh();
    monitor();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int target;
    target = frames_done + n;
    for (int i = 0; i < budget && frames_done < target; i++) tick();
    if (frames_done < target) check("frame_timeout", frames_done, target);
  endtask

  task automatic wait_start(input int budget);
    for (int i = 0; i < budget && !(mon_act && mon_cnt == 1); i++) tick();
    if (!(mon_act && mon_cnt == 1)) check("start_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int p0;
    int d0;
    bit bad;

    vecs[0] = '{data: 8'h48, gap: 3};
    vecs[1] = '{data: 8'h07, gap: 1};
    vecs[2] = '{data: 8'hFF, gap: 5};
    vecs[3] = '{data: 8'h00, gap: 2};
    vecs[4] = '{data: 8'h80, gap: 0};
    vecs[5] = '{data: 8'h01, gap: 4};
    vecs[6] = '{data: 8'hFE, gap: 1};
    vecs[7] = '{data: 8'h3C, gap: 2};

    reset_n = 1'b0;
    fifo_refresh();
    #1;
    repeat (3) tick();
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_read_en", {31'd0, fifo_read_en}, 32'd0);
    check("reset_tx_done", {31'd0, tx_done}, 32'd0);
    reset_n = 1'b1;

    // Empty FIFO: line must stay idle with no pops.
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_read_en !== 1'b0) bad = 1;
    end
    check("idle_empty_line", {31'd0, bad}, 32'd0);
    check("idle_empty_pops", pops, 32'd0);

    for (int i = 0; i < 8; i++) begin
      p0 = pops;
      d0 = done_cnt;
      push_byte(vecs[i].data);
      wait_frames(1, c_FB * c_CPB + 50);
      check("single_pop_count", pops - p0, 32'd1);
      check("single_done_count", done_cnt - d0, 32'd1);
      check("done_latency", last_done - last_start, c_FB * c_CPB);
      for (int g = 0; g < vecs[i].gap; g++) tick();
    end

    // Back-to-back frames with the FIFO held non-empty.
    p0 = pops;
    push_byte(8'h55);
    push_byte(8'hAA);
    wait_frames(2, 2 * c_FB * c_CPB + 50);
    check("b2b_start_spacing", last_start - prev_start, c_FB * c_CPB + 1);
    check("b2b_pop_count", pops - p0, 32'd2);
    repeat (4) tick();

    // Head word changes before the pop lands and a new word arrives mid-frame.
    push_byte(8'h41);
    wait_start(50);
    fq[0] = 8'h42;
    fifo_refresh();
    repeat (30) tick();
    push_byte(8'h42);
    wait_frames(2, 2 * c_FB * c_CPB + 50);
    check("midchange_start_spacing", last_start - prev_start, c_FB * c_CPB + 1);
    repeat (4) tick();

    // Abort a frame with reset at frame cycle 35.
    p0 = pops;
    push_byte(8'h0F);
    wait_start(50);
    repeat (35) tick();
    d0 = done_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_tx_done", {31'd0, tx_done}, 32'd0);
    sb.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad = 1;
    end
    check("post_abort_idle", {31'd0, bad}, 32'd0);
    check("post_abort_no_done", done_cnt - d0, 32'd0);
    check("post_abort_pops", pops - p0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
